// File: rtl/dom_pkg.sv
// Shared helpers for the domain-oriented masked AND: randomness count
// and the lexicographic share-pair index used to pick resharing words.
package dom_pkg;

    // Fresh random words consumed per operation for n shares.
    function automatic int nrand(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Lexicographic index of unordered pair {i,j}:
    // (0,1)=0, (0,2)=1, ..., (0,n-1), (1,2), ...
    function automatic int pair_idx(input int n, input int i, input int j);
        int a;
        int b;
        a = (i < j) ? i : j;
        b = (i < j) ? j : i;
        return a * n - (a * (a + 1)) / 2 + (b - a - 1);
    endfunction

endpackage

// File: rtl/dom_reg_stage.sv
// One-entry valid/ready register stage with full throughput.
// Ports: clk_i, rst_ni, in_valid_i/in_ready_o/in_data_i,
// out_valid_o/out_ready_i/out_data_o. Loads only on a transfer.
module dom_reg_stage #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign load        = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dom_and_nshare.sv
// Domain-oriented masked AND of NSHARES Boolean shares, WIDTH bits each.
// Ports: clk, rst_n, x_sh/y_sh (operand shares), z (NRAND random words),
// in_valid/in_ready, c_sh (result shares), out_valid/out_ready.
// Macro DOM_AND_OUTREG_EN adds a registered output stage (latency 2).
module dom_and_nshare
    import dom_pkg::*;
#(
    parameter  int NSHARES = 2,
    parameter  int WIDTH   = 1,
    localparam int NRAND   = nrand(NSHARES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSHARES*WIDTH-1:0] x_sh,
    input  logic [NSHARES*WIDTH-1:0] y_sh,
    input  logic [NRAND*WIDTH-1:0]   z,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NSHARES*WIDTH-1:0] c_sh,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int SW = NSHARES * WIDTH;

    logic [SW-1:0]   inner_d, cross_d;
    logic [SW-1:0]   inner_q, cross_q;
    logic [SW-1:0]   c_int;
    logic [2*SW-1:0] s1_data;
    logic            s1_valid, s1_ready;

    // Per domain: inner product kept apart from the resharing sum so no
    // unmasked cross-domain combination exists before the register.
    always_comb begin
        inner_d = '0;
        cross_d = '0;
        for (int i = 0; i < NSHARES; i++) begin
            inner_d[i*WIDTH +: WIDTH] =
                x_sh[i*WIDTH +: WIDTH] & y_sh[i*WIDTH +: WIDTH];
            for (int j = 0; j < NSHARES; j++) begin
                if (j != i) begin
                    cross_d[i*WIDTH +: WIDTH] ^=
                        (x_sh[i*WIDTH +: WIDTH] & y_sh[j*WIDTH +: WIDTH])
                        ^ z[pair_idx(NSHARES, i, j)*WIDTH +: WIDTH];
                end
            end
        end
    end

    dom_reg_stage #(
        .DATA_W (2*SW)
    ) u_stage1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({cross_d, inner_d}),
        .out_valid_o (s1_valid),
        .out_ready_i (s1_ready),
        .out_data_o  (s1_data)
    );

    assign inner_q = s1_data[SW-1:0];
    assign cross_q = s1_data[2*SW-1:SW];
    assign c_int   = inner_q ^ cross_q;

`ifdef DOM_AND_OUTREG_EN
    dom_reg_stage #(
        .DATA_W (SW)
    ) u_stage2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s1_ready),
        .in_data_i   (c_int),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (c_sh)
    );
`else
    assign s1_ready  = out_ready;
    assign out_valid = s1_valid;
    assign c_sh      = c_int;
`endif

endmodule

// File: tb/tb_dom_and_nshare.sv
// Self-checking bench for dom_and_nshare: directed vectors, stall,
// back-to-back, random stream and asynchronous reset scenarios.
module tb_dom_and_nshare;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NR = 3;
`ifdef DOM_AND_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] x_sh, y_sh, c_sh;
    logic [NR*W-1:0] z;
    logic           in_valid, in_ready, out_valid, out_ready;

    logic [1:0] x2, y2, c2;
    logic [0:0] z2;
    logic       iv2, ir2, ov2, or2;

    int tests;
    int fails;
    logic [W-1:0] q[$];

    dom_and_nshare #(.NSHARES(N), .WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_sh      (x_sh),
        .y_sh      (y_sh),
        .z         (z),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_sh      (c_sh),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    dom_and_nshare #(.NSHARES(2), .WIDTH(1)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_sh      (x2),
        .y_sh      (y2),
        .z         (z2),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .c_sh      (c2),
        .out_valid (ov2),
        .out_ready (or2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] unmask(input logic [N*W-1:0] s);
        return s[7:0] ^ s[15:8] ^ s[23:16];
    endfunction

    // Random operands with known plain values; returns plain X & Y.
    task automatic gen_op(output logic [W-1:0] ex);
        logic [W-1:0] xa, ya, s0, s1, t0, t1;
        xa = W'($urandom);
        ya = W'($urandom);
        s0 = W'($urandom);
        s1 = W'($urandom);
        t0 = W'($urandom);
        t1 = W'($urandom);
        x_sh = {xa ^ s0 ^ s1, s1, s0};
        y_sh = {ya ^ t0 ^ t1, t1, t0};
        z = NR*W'($urandom);
        ex = xa & ya;
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if (out_valid !== 1'b0 || c_sh !== '0 || ov2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: ov=%b c=%h req ov=0 c=0",
                     out_valid, c_sh);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || c_sh !== '0 || ir2 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: rdy=%b c=%h req rdy=1 c=0",
                     in_ready, c_sh);
        end
    endtask

    task automatic test_two_share;
        @(negedge clk);
        x2 = 2'b01;
        y2 = 2'b11;
        z2 = 1'b1;
        iv2 = 1'b1;
        or2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        tests++;
        if (ov2 !== 1'b1 || c2 !== 2'b11 || (c2[0] ^ c2[1]) !== 1'b0) begin
            fails++;
            $display("FAIL two_share: ov=%b c=%b req ov=1 c=11", ov2, c2);
        end
        @(negedge clk);
        tests++;
        if (ov2 !== 1'b0) begin
            fails++;
            $display("FAIL two_share_drain: ov=%b req 0", ov2);
        end
    endtask

    task automatic test_directed;
        logic [N*W-1:0]  tx[2];
        logic [N*W-1:0]  ty[2];
        logic [NR*W-1:0] tz[2];
        logic [N*W-1:0]  tc[2];
        tx[0] = {8'h00, 8'h0F, 8'hF0};
        ty[0] = {8'h00, 8'h00, 8'hAA};
        tz[0] = {8'h04, 8'h02, 8'h01};
        tc[0] = {8'h06, 8'h0F, 8'hA3};
        tx[1] = {8'hFF, 8'hFF, 8'hFF};
        ty[1] = {8'h00, 8'hF0, 8'h0F};
        tz[1] = '0;
        tc[1] = {8'hFF, 8'hFF, 8'hFF};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            x_sh = tx[v];
            y_sh = ty[v];
            z = tz[v];
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || c_sh !== tc[v]) begin
                fails++;
                $display("FAIL directed_%0d: ov=%b c=%h req ov=1 c=%h",
                         v, out_valid, c_sh, tc[v]);
            end
            tests++;
            if (unmask(c_sh) !== unmask(tc[v])) begin
                fails++;
                $display("FAIL directed_unmask_%0d: got %h req %h",
                         v, unmask(c_sh), unmask(tc[v]));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        logic [N*W-1:0] exp_c;
        exp_c = {8'h06, 8'h0F, 8'hA3};
        @(negedge clk);
        x_sh = {8'h00, 8'h0F, 8'hF0};
        y_sh = {8'h00, 8'h00, 8'hAA};
        z = {8'h04, 8'h02, 8'h01};
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        x_sh = '1;
        y_sh = '1;
        repeat (LAT - 1) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (out_valid !== 1'b1 || c_sh !== exp_c) begin
                fails++;
                $display("FAIL stall_hold_%0d: ov=%b c=%h req ov=1 c=%h",
                         c, out_valid, c_sh, exp_c);
            end
`ifndef DOM_AND_OUTREG_EN
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_ready_%0d: rdy=%b req 0", c, in_ready);
            end
`endif
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain: ov=%b req 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ex;
        int sent, got, first, last;
        sent = 0;
        got = 0;
        first = -1;
        last = -1;
        q.delete();
        for (int cyc = 0; cyc < 16 + LAT + 3; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (sent < 16);
            if (in_valid) gen_op(ex);
            #1;
            if (out_valid) begin
                tests++;
                if (q.size() == 0 || c_sh === 'x || unmask(c_sh) !== q[0]) begin
                    fails++;
                    $display("FAIL b2b_data: got %h req %h", unmask(c_sh),
                             (q.size() != 0) ? q[0] : 8'h00);
                end
                if (q.size() != 0) void'(q.pop_front());
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ex);
                sent++;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (got != 16 || last - first != 15) begin
            fails++;
            $display("FAIL b2b_rate: got=%0d span=%0d req 16/15",
                     got, last - first);
        end
    endtask

    task automatic test_random_stream;
        logic [W-1:0] ex;
        int sent, cyc;
        sent = 0;
        cyc = 0;
        q.delete();
        while ((sent < 1000 || q.size() != 0) && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            if (in_valid) gen_op(ex);
            #1;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: got %h req none",
                             unmask(c_sh));
                end else begin
                    if (unmask(c_sh) !== q[0]) begin
                        fails++;
                        $display("FAIL stream_data: got %h req %h",
                                 unmask(c_sh), q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ex);
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (sent != 1000 || q.size() != 0) begin
            fails++;
            $display("FAIL stream_done: sent=%0d left=%0d req 1000/0",
                     sent, q.size());
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        x_sh = {8'hFF, 8'hFF, 8'hFF};
        y_sh = {8'h00, 8'hF0, 8'h0F};
        z = '0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: ov=%b req 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || c_sh !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL areset: ov=%b c=%h rdy=%b req 0/0/1",
                     out_valid, c_sh, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        x_sh = '0;
        y_sh = '0;
        z = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x2 = '0;
        y2 = '0;
        z2 = '0;
        iv2 = 1'b0;
        or2 = 1'b0;
        test_reset;
        test_two_share;
        test_directed;
        test_stall;
        test_back_to_back;
        test_random_stream;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dom_and_nshare.md
DOM_AND_NSHARE -- requirements
Module: dom_and_nshare

Interface
REQ-001 Parameter NSHARES, default 2: number of Boolean shares per operand (masking order NSHARES-1); legal 2..5.
REQ-002 Parameter WIDTH, default 1: bits per share; each bit is an independent masked AND.
REQ-003 Derived NRAND = NSHARES*(NSHARES-1)/2: fresh random words consumed per operation.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 x_sh  in  NSHARES*WIDTH  operand X shares; share i at bits [i*WIDTH +: WIDTH].
REQ-007 y_sh  in  NSHARES*WIDTH  operand Y shares; same packing.
REQ-008 z  in  NRAND*WIDTH  fresh randomness; word k at bits [k*WIDTH +: WIDTH].
REQ-009 in_valid / in_ready  in / out  1 each  input handshake.
REQ-010 c_sh  out  NSHARES*WIDTH  result shares, same packing.
REQ-011 out_valid / out_ready  out / in  1 each  output handshake.

Function
REQ-012 Pair index k for share pair (i,j), i<j, SHALL be lexicographic: (0,1)=0, (0,2)=1, ..., (0,N-1), (1,2), ...
REQ-013 Stage-1 register, share i, SHALL capture inner term x_i&y_i separately from the sum of resharing terms (x_i&y_j ^ z_k) over all j!=i, k = pair index of {i,j}.
REQ-014 Inner and cross terms SHALL both be registered; no combinational path from x_sh/y_sh to c_sh (glitch isolation between domains).
REQ-015 c_sh share i SHALL equal XOR of registered inner term and registered cross sum for domain i.
REQ-016 Correctness: XOR of all c_sh shares SHALL equal (XOR of x_sh shares) & (XOR of y_sh shares), bitwise.
REQ-017 Transfer occurs when in_valid && in_ready; stage registers SHALL load only on transfer and hold otherwise (no toggling on idle/stall).
REQ-018 in_ready SHALL equal !out_valid || out_ready (one-entry pipeline, full throughput).
REQ-019 Latency: result SHALL appear with out_valid=1 the cycle after acceptance (1 cycle, macro absent).
REQ-020 out_valid && !out_ready: c_sh and out_valid SHALL hold unchanged; in_ready=0.
REQ-021 Simultaneous drain and accept (out_valid, out_ready, in_valid all 1): new result SHALL replace old in same edge; out_valid stays 1.
REQ-022 out_valid SHALL fall the cycle after a drain with no simultaneous accept.
REQ-023 z SHALL be sampled only on transfer; each accepted operation consumes NRAND fresh words.

Reset
REQ-024 rst_n low SHALL immediately clear out_valid and all share registers to 0, regardless of clock; in-flight operation is discarded.
REQ-025 After reset release, in_ready SHALL be 1 and c_sh SHALL read all-zero until first result.

Configuration
REQ-026 Macro DOM_AND_OUTREG_EN defined: an additional registered stage after integration SHALL hold c_sh; latency 2 cycles; each stage follows REQ-017/018 rules with its own valid; throughput remains 1 per cycle.
REQ-027 Macro undefined: integration XOR is combinational from stage-1 registers; latency 1 cycle.

Structure
REQ-028 Shared package dom_pkg SHALL hold the NRAND computation function and the pair-index function used by REQ-012.
REQ-029 The valid/ready register stage SHALL be sub-module dom_reg_stage (parameter DATA_W), instantiated once, or twice with DOM_AND_OUTREG_EN.

Verification
REQ-030 NSHARES=2, WIDTH=1, x_sh=(1,0), y_sh=(1,1), z=1, out_ready=1 -> next cycle out_valid=1, c_sh=(1,1), unmasked 0.
REQ-031 NSHARES=3, WIDTH=8, 1000 random operands and z, out_ready random -> every unmasked result equals X&Y, in order, no loss or duplication.
REQ-032 Accept one op, hold out_ready=0 for 3 cycles -> c_sh stable, out_valid=1, in_ready=0 throughout; release -> drained next edge.
REQ-033 Continuous in_valid=1, out_ready=1 for 16 ops -> 16 results on 16 consecutive cycles.
REQ-034 rst_n low mid-cycle with out_valid=1 -> out_valid=0 and c_sh=0 before next clock edge.
REQ-035 With DOM_AND_OUTREG_EN, REQ-030 stimulus -> result 2 cycles after acceptance; REQ-033 throughput unchanged.
